// File: rtl/vector_reg_file.sv
// Bank of NREGS vector registers (LANES x WIDTH) with one lane-masked write port,
// two registered read ports and a per-register busy scoreboard. Optional macro: VRF_WRITE_BYPASS_EN.
module vector_reg_file #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int NREGS = 8,
   parameter int AW    = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [LANES-1:0]       wr_mask,
   input  logic [LANES*WIDTH-1:0] wr_data,
   input  logic                   rd_en,
   input  logic [AW-1:0]          rd_addr_a,
   input  logic [AW-1:0]          rd_addr_b,
   output logic [LANES*WIDTH-1:0] rd_data_a,
   output logic [LANES*WIDTH-1:0] rd_data_b,
   output logic                   rd_valid,
   input  logic                   rsv_en,
   input  logic [AW-1:0]          rsv_addr,
   output logic                   rsv_ok,
   output logic [NREGS-1:0]       busy
);

   localparam int DW = LANES * WIDTH;

   logic [DW-1:0]    mem_q [NREGS];
   logic [DW-1:0]    mem_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [DW-1:0]    rd_data_a_q, rd_data_a_d;
   logic [DW-1:0]    rd_data_b_q, rd_data_b_d;
   logic             rd_valid_q, rd_valid_d;

   logic [DW-1:0]    wr_bitmask;
   logic [DW-1:0]    rd_word_a, rd_word_b;
   logic             fwd_a, fwd_b;

   // Expand the per-lane mask to a per-bit mask so merges are plain AND/OR.
   always_comb begin
      wr_bitmask = '0;
      for (int i = 0; i < LANES; i++) begin
         wr_bitmask[i*WIDTH +: WIDTH] = {WIDTH{wr_mask[i]}};
      end
   end

   // Storage next state. Addresses outside 0..NREGS-1 never match a register.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         mem_d[r] = mem_q[r];
         if (clr) begin
            mem_d[r] = '0;
         end else if (wr_en && (wr_addr == AW'(r))) begin
            mem_d[r] = (mem_q[r] & ~wr_bitmask) | (wr_data & wr_bitmask);
         end
      end
   end

`ifdef VRF_WRITE_BYPASS_EN
   assign fwd_a = wr_en && !clr && (rd_addr_a == wr_addr);
   assign fwd_b = wr_en && !clr && (rd_addr_b == wr_addr);
`else
   assign fwd_a = 1'b0;
   assign fwd_b = 1'b0;
`endif

   // Read lookup; unmatched (out-of-range) addresses return zero.
   always_comb begin
      rd_word_a = '0;
      rd_word_b = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (rd_addr_a == AW'(r)) begin
            rd_word_a = fwd_a ? ((mem_q[r] & ~wr_bitmask) | (wr_data & wr_bitmask))
                              : mem_q[r];
         end
         if (rd_addr_b == AW'(r)) begin
            rd_word_b = fwd_b ? ((mem_q[r] & ~wr_bitmask) | (wr_data & wr_bitmask))
                              : mem_q[r];
         end
      end
   end

   always_comb begin
      rd_valid_d  = rd_en;
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
      if (rd_en) begin
         rd_data_a_d = rd_word_a;
         rd_data_b_d = rd_word_b;
      end
   end

   // Write clears the bit first; a reservation only lands if the bit was free
   // before the edge, so a write against a busy register leaves it free.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         busy_d[r] = busy_q[r];
         if (clr) begin
            busy_d[r] = 1'b0;
         end else begin
            if (wr_en && (wr_addr == AW'(r))) busy_d[r] = 1'b0;
            if (rsv_en && (rsv_addr == AW'(r)) && !busy_q[r]) busy_d[r] = 1'b1;
         end
      end
   end

   always_comb begin
      rsv_ok = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         if (rsv_addr == AW'(r)) rsv_ok = ~busy_q[r];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
         busy_q      <= '0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         busy_q      <= busy_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign rd_valid  = rd_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_vector_reg_file.sv
// Directed bench for vector_reg_file: reset, lane-masked writes, read hold,
// read-during-write, scoreboard, clear and reset during a read.
module tb_vector_reg_file;

   localparam int WIDTH = 8;
   localparam int LANES = 4;
   localparam int NREGS = 8;
   localparam int AW    = 3;
   localparam int DW    = LANES * WIDTH;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clr = 1'b0;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [LANES-1:0] wr_mask = '0;
   logic [DW-1:0]    wr_data = '0;
   logic             rd_en = 1'b0;
   logic [AW-1:0]    rd_addr_a = '0;
   logic [AW-1:0]    rd_addr_b = '0;
   logic [DW-1:0]    rd_data_a;
   logic [DW-1:0]    rd_data_b;
   logic             rd_valid;
   logic             rsv_en = 1'b0;
   logic [AW-1:0]    rsv_addr = '0;
   logic             rsv_ok;
   logic [NREGS-1:0] busy;

   int checks = 0;
   int errors = 0;

   vector_reg_file #(.WIDTH(WIDTH), .LANES(LANES), .NREGS(NREGS), .AW(AW)) dut (
      .clk(clk), .reset(reset), .clr(clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 1'b0; wr_en = 1'b0; wr_mask = '0; wr_data = '0;
      rd_en = 1'b0; rsv_en = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL reset_rd_a got %h exp %h", rd_data_a, 32'h0); end
      checks++; if (rd_data_b !== 32'h0) begin errors++; $display("FAIL reset_rd_b got %h exp %h", rd_data_b, 32'h0); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
      checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_lane_mask();
      wr_en = 1'b1; wr_addr = 3'd3; wr_mask = 4'b1111; wr_data = 32'h44332211;
      step();
      wr_mask = 4'b0101; wr_data = 32'hAABBCCDD;
      step();
      idle_inputs();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mask_pre_valid got %b exp 0", rd_valid); end
      rd_en = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
      step();
      rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mask_rd_valid got %b exp 1", rd_valid); end
      checks++; if (rd_data_a !== 32'h44BB22DD) begin errors++; $display("FAIL mask_rd_a got %h exp %h", rd_data_a, 32'h44BB22DD); end
      checks++; if (rd_data_b !== 32'h44BB22DD) begin errors++; $display("FAIL mask_rd_b_same_addr got %h exp %h", rd_data_b, 32'h44BB22DD); end
   endtask

   task automatic test_read_hold();
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_%0d got %b exp 0", k, rd_valid); end
         checks++; if (rd_data_a !== 32'h44BB22DD) begin errors++; $display("FAIL hold_rd_a_%0d got %h exp %h", k, rd_data_a, 32'h44BB22DD); end
      end
   endtask

   task automatic test_read_during_write();
      logic [DW-1:0] exp_a;
`ifdef VRF_WRITE_BYPASS_EN
      exp_a = 32'h01020304;
`else
      exp_a = 32'h00000000;
`endif
      wr_en = 1'b1; wr_addr = 3'd2; wr_mask = 4'b1111; wr_data = 32'h01020304;
      rd_en = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd3;
      step();
      idle_inputs();
      checks++; if (rd_data_a !== exp_a) begin errors++; $display("FAIL rdw_rd_a got %h exp %h", rd_data_a, exp_a); end
      checks++; if (rd_data_b !== 32'h44BB22DD) begin errors++; $display("FAIL rdw_rd_b got %h exp %h", rd_data_b, 32'h44BB22DD); end
      rd_en = 1'b1; rd_addr_a = 3'd2;
      step();
      rd_en = 1'b0;
      checks++; if (rd_data_a !== 32'h01020304) begin errors++; $display("FAIL rdw_after got %h exp %h", rd_data_a, 32'h01020304); end
   endtask

   task automatic test_scoreboard();
      rsv_addr = 3'd5;
      #1;
      checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL sb_ok_free got %b exp 1", rsv_ok); end
      rsv_en = 1'b1;
      step();
      checks++; if (busy !== 8'h20) begin errors++; $display("FAIL sb_rsv got %h exp 20", busy); end
      checks++; if (rsv_ok !== 1'b0) begin errors++; $display("FAIL sb_ok_busy got %b exp 0", rsv_ok); end
      step();
      checks++; if (busy !== 8'h20) begin errors++; $display("FAIL sb_rsv_again got %h exp 20", busy); end
      // Mask-zero write: no data change, busy still released.
      rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd5; wr_mask = 4'b0000; wr_data = 32'hDEADBEEF;
      step();
      checks++; if (busy !== 8'h00) begin errors++; $display("FAIL sb_wr_clear got %h exp 00", busy); end
      rsv_en = 1'b1;
      step();
      checks++; if (busy !== 8'h20) begin errors++; $display("FAIL sb_rsv_wr_free got %h exp 20", busy); end
      step();
      checks++; if (busy !== 8'h00) begin errors++; $display("FAIL sb_rsv_wr_busy got %h exp 00", busy); end
      rsv_addr = 3'd6; wr_addr = 3'd1;
      step();
      checks++; if (busy !== 8'h40) begin errors++; $display("FAIL sb_indep got %h exp 40", busy); end
      idle_inputs();
      rd_en = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd1;
      step();
      rd_en = 1'b0;
      checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL sb_mask0_data got %h exp 0", rd_data_a); end
   endtask

   task automatic test_clr();
      for (int r = 0; r < NREGS; r++) begin
         wr_en = 1'b1; wr_addr = AW'(r); wr_mask = 4'b1111; wr_data = 32'hFFFFFFFF;
         step();
      end
      idle_inputs();
      rsv_en = 1'b1; rsv_addr = 3'd4;
      step();
      checks++; if (busy !== 8'h10) begin errors++; $display("FAIL clr_pre_busy got %h exp 10", busy); end
      clr = 1'b1; rsv_addr = 3'd2;
      wr_en = 1'b1; wr_addr = 3'd1; wr_mask = 4'b1111; wr_data = 32'h12345678;
      rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd4;
      step();
      idle_inputs();
      checks++; if (rd_data_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL clr_cycle_rd_a got %h exp %h", rd_data_a, 32'hFFFFFFFF); end
      checks++; if (rd_data_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL clr_cycle_rd_b got %h exp %h", rd_data_b, 32'hFFFFFFFF); end
      checks++; if (busy !== 8'h00) begin errors++; $display("FAIL clr_busy got %h exp 00", busy); end
      rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd7;
      step();
      rd_en = 1'b0;
      checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL clr_after_rd_a got %h exp 0", rd_data_a); end
      checks++; if (rd_data_b !== 32'h0) begin errors++; $display("FAIL clr_after_rd_b got %h exp 0", rd_data_b); end
   endtask

   task automatic test_reset_mid();
      wr_en = 1'b1; wr_addr = 3'd0; wr_mask = 4'b1111; wr_data = 32'hCAFEF00D;
      rsv_en = 1'b1; rsv_addr = 3'd1;
      step();
      idle_inputs();
      rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
      step();
      checks++; if (rd_data_a !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_pre_rd_a got %h exp %h", rd_data_a, 32'hCAFEF00D); end
      checks++; if (busy !== 8'h02) begin errors++; $display("FAIL mid_pre_busy got %h exp 02", busy); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL mid_rst_rd_a got %h exp 0", rd_data_a); end
      checks++; if (rd_data_b !== 32'h0) begin errors++; $display("FAIL mid_rst_rd_b got %h exp 0", rd_data_b); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", rd_valid); end
      checks++; if (busy !== 8'h00) begin errors++; $display("FAIL mid_rst_busy got %h exp 00", busy); end
      idle_inputs();
      step();
      reset = 1'b0;
      step();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_release_valid got %b exp 0", rd_valid); end
      rd_en = 1'b1; rd_addr_a = 3'd0;
      step();
      rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %b exp 1", rd_valid); end
      checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL mid_new_rd_a got %h exp 0", rd_data_a); end
   endtask

   initial begin
      test_reset();
      test_lane_mask();
      test_read_hold();
      test_read_during_write();
      test_scoreboard();
      test_clr();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
